mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative, parametrised multiply/divide unit for the MIPS datapath, implementing MULT, MULTU, DIV and DIVU into a HI/LO result pair. It extends the single-cycle combinational adder into a multi-cycle arithmetic block. It uses one shift-add or shift-subtract step per clock, with busy/done handshaking toward the control unit. HI/LO are held inside the block and read by MFHI/MFLO paths.

## Interface
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; WIDTH ≥ 4.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  multiplicand / dividend (rs); latched on accepted start.
- b  input  WIDTH  multiplier / divisor (rt); latched on accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo/div_by_zero updated this cycle.
- hi  output  WIDTH  MULT*: upper product half; DIV*: remainder.
- lo  output  WIDTH  MULT*: lower product half; DIV*: quotient.
- div_by_zero  output  1  set with done when a DIV/DIVU had b=0; cleared on the next accepted start.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start=1: latch a, b, op. Convert signed ops to magnitudes and record result signs. Load WIDTH-bit step counter. Go to RUN.
- IDLE/DONE + start=0: go to IDLE. DONE always lasts exactly one cycle.
- RUN, multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
- RUN, divide: one restoring shift-subtract step per cycle; quotient bit = 1 when the trial remainder is ≥ 0.
- RUN ends after exactly WIDTH steps, then goes to FIX.
- FIX, MULT: negate the 2*WIDTH product if operand signs differ.
- FIX, DIV: negate the quotient if signs differ; remainder takes the dividend's sign (truncation toward zero).
- FIX writes hi/lo and goes to DONE.
- Divide by zero (b=0, DIV or DIVU): still takes full latency. lo = all ones, hi = a (original, unmodified), div_by_zero=1.
- Signed overflow (DIV, a = most-negative, b = −1): lo = a, hi = 0, div_by_zero=0.
- start while busy=1 is ignored, with no queueing. Changes on a/b/op after acceptance have no effect.
- hi/lo hold their values between completions; they are written only in FIX or by reset.
- Internal arithmetic is 2*WIDTH+1 bits wide, so there is no intermediate overflow. Outputs are truncated to WIDTH per half.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, state=IDLE, counter=0.
- Reset during RUN/FIX/DONE: next cycle returns to IDLE with all outputs at reset values. The aborted operation never asserts done.
- Cycle 0 = rising edge that samples start=1 with busy=0.
- busy=1 during cycles 1 … WIDTH+1 (RUN for WIDTH cycles, FIX for 1).
- done=1 and busy=0 in cycle WIDTH+2. hi/lo are valid from that cycle onward. For WIDTH=32, done is in cycle 34.
- A start sampled in the DONE cycle is accepted, so back-to-back throughput is one op per WIDTH+2 cycles.
- Reset and start asserted together: reset wins.

## Test plan
- MULTU a=10, b=20 → done exactly at cycle 34 (busy=1 in cycles 1–33); hi=0x00000000, lo=0x000000C8.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0xFFFFFFFF, b=16 → lo=0x0FFFFFFF, hi=0x0000000F.
- DIVU a=45, b=0 → lo=0xFFFFFFFF, hi=45, div_by_zero=1 with done. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 40×45 and pulse start with op=DIVU at cycle 5 → second start ignored; result lo=1800. New start in the done cycle → accepted, with its done 34 cycles later.
- Start MULTU 10×50, assert reset at cycle 10 → busy=0 at cycle 11; hi=lo=0; no done pulse ever appears for that operation.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per clock,
// producing a HI/LO pair with a busy/done handshake toward the control unit.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] a_orig_q, mag_b_q, hi_q, lo_q;
  logic             is_div_q, b_zero_q, neg_lo_q, neg_hi_q;
  logic             busy_q, done_q, dbz_q;

  // Operand conditioning for an incoming start
  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - a) : a;
    b_mag     = b_neg ? (WIDTH'(0) - b) : b;
  end

  // One iteration step; acc holds {upper/remainder (WIDTH+1), multiplier/quotient (WIDTH)}
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [AW-1:0]      mul_next, div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {2'b00, mag_b_q};
    // Negative trial remainder: restore and shift in a zero quotient bit
    div_next = trial[WIDTH+1] ? {rem_sh, acc_q[WIDTH-2:0], 1'b0}
                              : {trial[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix = neg_lo_q ? ((2*WIDTH)'(0) - acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0];
    quot_fix = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      a_orig_q <= '0;
      mag_b_q  <= '0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StRun;
            count_q  <= CW'(WIDTH);
            acc_q    <= {{(WIDTH + 1){1'b0}}, a_mag};
            a_orig_q <= a;
            mag_b_q  <= b_mag;
            is_div_q <= op[1];
            b_zero_q <= (b == '0);
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q   <= is_div_q ? div_next : mul_next;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) state_q <= StFix;
        end
        StFix: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_zero_q) begin
            hi_q  <= a_orig_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pairs are queued at issue time and checked
// against the DUT when done is observed, together with latency and busy timing.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_dbz;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge, then scramble the operands to show they are not re-sampled
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic z);
    exp_t e;
    e.e_hi  = h;
    e.e_lo  = l;
    e.e_dbz = z;
    sb.push_back(e);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, p, q, r;
    logic [63:0] u, v;
    sx = $signed(x);
    sy = $signed(y);
    e.e_dbz = 1'b0;
    case (o)
      2'd0: begin
        p = sx * sy;
        u = p;
        e.e_hi = u[63:32];
        e.e_lo = u[31:0];
      end
      2'd1: begin
        u = {32'b0, x} * {32'b0, y};
        e.e_hi = u[63:32];
        e.e_lo = u[31:0];
      end
      default: begin
        if (y == '0) begin
          e.e_hi  = x;
          e.e_lo  = '1;
          e.e_dbz = 1'b1;
        end else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          u = q;
          v = r;
          e.e_lo = u[31:0];
          e.e_hi = v[31:0];
        end else begin
          e.e_lo = x / y;
          e.e_hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Wait (bounded) for done starting from cycle c0; check busy, latency and the queued result
  task automatic finish_op(input string tag, input int c0, input int lat);
    int   c;
    exp_t e;
    c = c0;
    while (!done && c < lat + 6) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      step();
      c++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(c), 64'(lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.e_hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.e_lo));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.e_dbz));
    end
  endtask

  initial begin
    exp_t        e;
    int          dones;
    logic [1:0]  ro;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    step();

    push(32'h0, 32'hC8, 1'b0);
    issue(2'd1, 32'd10, 32'd20);
    finish_op("multu_10x20", 1, 34);

    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult_neg3x7", 1, 34);

    push(32'hFFFF_FFFE, 32'h1, 1'b0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1, 34);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg7_2", 1, 34);

    push(32'hF, 32'h0FFF_FFFF, 1'b0);
    issue(2'd3, 32'hFFFF_FFFF, 32'd16);
    finish_op("divu_max_16", 1, 34);

    push(32'd45, 32'hFFFF_FFFF, 1'b1);
    issue(2'd3, 32'd45, 32'd0);
    finish_op("divu_by_zero", 1, 34);
    step();
    step();
    check("hold_hi", 64'(hi), 64'd45);
    check("hold_dbz", 64'(div_by_zero), 64'd1);
    check("hold_done_low", 64'(done), 64'd0);

    push(32'h0, 32'h8000_0000, 1'b0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);
    finish_op("div_overflow", 1, 34);

    for (int i = 0; i < 4; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = $urandom;
      if (i >= 2) rb = rb >> (4 * i);
      e = model(ro, ra, rb);
      sb.push_back(e);
      issue(ro, ra, rb);
      finish_op($sformatf("rand%0d", i), 1, 34);
    end

    // Second start while busy must be ignored; a start in the done cycle is accepted
    push(32'h0, 32'd1800, 1'b0);
    issue(2'd1, 32'd40, 32'd45);
    step();
    step();
    step();
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd100;
    b     = 32'd7;
    step();
    start = 1'b0;
    finish_op("busy_start_ignored", 5, 34);
    e = model(2'd0, 32'hFFFF_FFFB, 32'd9);
    sb.push_back(e);
    issue(2'd0, 32'hFFFF_FFFB, 32'd9);
    finish_op("back_to_back", 1, 34);

    // Abort a multiply with reset at cycle 10
    issue(2'd1, 32'd10, 32'd50);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      step();
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    op    = 2'd1;
    a     = 32'd3;
    b     = 32'd3;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    step();
    check("rst_start_busy_after", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
